vga_bram_display: RTL and testbench

//  VGA 640x480@60 timing generator that scans a 160x240 RGB565 framebuffer held in an external

---
 rtl/vga_bram_display_if.sv | 35 +++
 rtl/vga_bram_display.sv | 214 +++++++++++++++++++++
 tb/tb_vga_bram_display.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/vga_bram_display_if.sv
`default_nettype none
// ============================================================================
// Interface : vga_bram_display_if
// Brief     : VGA pin bundle plus the BRAM port-B read bus of the
//             framebuffer scanner. The master is the display engine, the
//             slave is the BRAM/DAC side.
// Revision  : 1.0 - initial release
// ============================================================================
interface vga_bram_display_if;
  logic        vga_hsync;
  logic        vga_vsync;
  logic [15:0] vga_rgb;
  logic [31:0] bram_addr;
  logic [31:0] bram_din;
  logic        bram_en;

  modport master (
    output vga_hsync,
    output vga_vsync,
    output vga_rgb,
    output bram_addr,
    output bram_en,
    input  bram_din
  );

  modport slave (
    input  vga_hsync,
    input  vga_vsync,
    input  vga_rgb,
    input  bram_addr,
    input  bram_en,
    output bram_din
  );
endinterface
`default_nettype wire

// File: rtl/vga_bram_display.sv
`default_nettype none
// ============================================================================
// Module   : vga_bram_display
// Brief    : 640x480@60 VGA timing generator that scans an RGB565
//            framebuffer (two pixels per 32-bit BRAM word) out of an external
//            BRAM read port with 1-cycle latency, upscaled H_ACTIVE/FB_W
//            horizontally and V_ACTIVE/FB_H vertically.
// Options  : VGA_TEST_PATTERN_EN - bypass the BRAM and show 8 colour bars.
// Revision : 1.0 - initial release
// ============================================================================
//
// Pipeline (one raster position per clock):
//   edge k   : counters move to position P; the fetch for P is registered
//              from the look-ahead counter value, so bram_en/bram_addr for P
//              are visible in the same cycle as P.
//   edge k+1 : BRAM samples the address; stage 1 decodes P (active, syncs,
//              which half of the word).
//   edge k+2 : output registers take sync/colour for P; the first pixel of a
//              word is taken straight from bram_din into the output register.
// So every output appears two clocks after the counters reach its position.
//
// Reset parks the counters on the last position of the frame, so the first
// clock after reset lands on (0,0) and immediately issues the fetch for
// word 0 while all outputs start from their idle values.
module vga_bram_display #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_W     = 160,
  parameter int FB_H     = 240
) (
  input  logic               clk,
  input  logic               reset,
  vga_bram_display_if.master bus
);

  // Raster constants; 10-bit counters cover totals up to 1024.
  localparam int         c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] c_h_last   = 10'(c_h_total - 1);
  localparam logic [9:0] c_v_last   = 10'(c_v_total - 1);
  localparam logic [9:0] c_h_act    = 10'(H_ACTIVE);
  localparam logic [9:0] c_v_act    = 10'(V_ACTIVE);
  localparam logic [9:0] c_hs_start = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_hs_end   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] c_vs_start = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_vs_end   = 10'(V_ACTIVE + V_FP + V_SYNC);
  // Clocks per displayed FB pixel, and per 32-bit word (two pixels).
  localparam logic [9:0] c_h_scale  = 10'(H_ACTIVE / FB_W);
  localparam logic [9:0] c_span     = 10'(2 * (H_ACTIVE / FB_W));

  // Raster counters and look-ahead position.
  logic [9:0]  r_hcnt;
  logic [9:0]  r_vcnt;
  logic [9:0]  w_h_nxt;
  logic [9:0]  w_v_nxt;
  logic        w_cur_active;

  // Fetch port registers.
  logic        r_bram_en;
  logic [31:0] r_bram_addr;

  // Stage 1: decoded position whose BRAM read is in flight.
  logic        r_s1_active;
  logic        r_s1_hsync;
  logic        r_s1_vsync;
  logic        r_s1_first;
  logic        r_s1_upper;

  // Stage 2: output registers.
  logic        r_hsync;
  logic        r_vsync;
  logic [15:0] r_rgb;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] c_bar_w = 10'(H_ACTIVE / 8);
  logic [2:0]  r_s1_bar;
  logic [15:0] w_bar_rgb;
`else
  localparam logic [9:0]  c_v_scale = 10'(V_ACTIVE / FB_H);
  localparam logic [31:0] c_wpr     = 32'(FB_W / 2);
  logic        w_fetch;
  logic [31:0] w_fetch_word;
  logic [31:0] r_word;
`endif

  // Next raster position: h wraps at the line end and carries into v.
  always_comb begin
    w_h_nxt = r_hcnt + 10'd1;
    w_v_nxt = r_vcnt;
    if (r_hcnt == c_h_last) begin
      w_h_nxt = 10'd0;
      w_v_nxt = (r_vcnt == c_v_last) ? 10'd0 : r_vcnt + 10'd1;
    end
  end

  assign w_cur_active = (r_hcnt < c_h_act) && (r_vcnt < c_v_act);

`ifndef VGA_TEST_PATTERN_EN
  // Fetch decision for the position the counters move to on this edge.
  always_comb begin
    w_fetch      = (w_h_nxt < c_h_act) && (w_v_nxt < c_v_act) &&
                   ((w_h_nxt % c_span) == 10'd0);
    w_fetch_word = 32'(w_v_nxt / c_v_scale) * c_wpr + 32'(w_h_nxt / c_span);
  end
`endif

  // Raster counters and registered BRAM fetch port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcnt      <= c_h_last;
      r_vcnt      <= c_v_last;
      r_bram_en   <= 1'b0;
      r_bram_addr <= 32'd0;
    end else begin
      r_hcnt <= w_h_nxt;
      r_vcnt <= w_v_nxt;
`ifdef VGA_TEST_PATTERN_EN
      r_bram_en   <= 1'b0;
      r_bram_addr <= 32'd0;
`else
      r_bram_en <= w_fetch;
      if (w_fetch) begin
        r_bram_addr <= {w_fetch_word[29:0], 2'b00};
      end
`endif
    end
  end

  // Stage 1: decode blanking, syncs and pixel slot of the current position.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_active <= 1'b0;
      r_s1_hsync  <= 1'b1;
      r_s1_vsync  <= 1'b1;
      r_s1_first  <= 1'b0;
      r_s1_upper  <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      r_s1_bar    <= 3'd0;
`endif
    end else begin
      r_s1_active <= w_cur_active;
      r_s1_hsync  <= ~((r_hcnt >= c_hs_start) && (r_hcnt < c_hs_end));
      r_s1_vsync  <= ~((r_vcnt >= c_vs_start) && (r_vcnt < c_vs_end));
      r_s1_first  <= (r_hcnt % c_span) == 10'd0;
      r_s1_upper  <= ((r_hcnt / c_h_scale) % 10'd2) != 10'd0;
`ifdef VGA_TEST_PATTERN_EN
      r_s1_bar    <= 3'(r_hcnt / c_bar_w);
`endif
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  // Colour of each of the eight vertical bars.
  always_comb begin
    w_bar_rgb = 16'h0000;
    case (r_s1_bar)
      3'd0:    w_bar_rgb = 16'hFFFF;
      3'd1:    w_bar_rgb = 16'hFFE0;
      3'd2:    w_bar_rgb = 16'h07FF;
      3'd3:    w_bar_rgb = 16'h07E0;
      3'd4:    w_bar_rgb = 16'hF81F;
      3'd5:    w_bar_rgb = 16'hF800;
      3'd6:    w_bar_rgb = 16'h001F;
      default: w_bar_rgb = 16'h0000;
    endcase
  end
`endif

  // Stage 2: output registers; the word-start pixel comes directly from
  // bram_din, the remaining slots from the held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb   <= 16'h0000;
`ifndef VGA_TEST_PATTERN_EN
      r_word  <= 32'd0;
`endif
    end else begin
      r_hsync <= r_s1_hsync;
      r_vsync <= r_s1_vsync;
`ifdef VGA_TEST_PATTERN_EN
      r_rgb   <= r_s1_active ? w_bar_rgb : 16'h0000;
`else
      if (r_s1_active && r_s1_first) begin
        r_word <= bus.bram_din;
      end
      if (!r_s1_active) begin
        r_rgb <= 16'h0000;
      end else if (r_s1_first) begin
        r_rgb <= bus.bram_din[15:0];
      end else if (r_s1_upper) begin
        r_rgb <= r_word[31:16];
      end else begin
        r_rgb <= r_word[15:0];
      end
`endif
    end
  end

  assign bus.vga_hsync = r_hsync;
  assign bus.vga_vsync = r_vsync;
  assign bus.vga_rgb   = r_rgb;
  assign bus.bram_en   = r_bram_en;
  assign bus.bram_addr = r_bram_addr;

endmodule
`default_nettype wire

// File: tb/tb_vga_bram_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_bram_display
// Brief    : Self-checking bench for vga_bram_display. Two instances share
//            clock and reset: the full 640x480 geometry (first lines of a
//            frame) and a reduced geometry with the same 4x/2x scaling whose
//            whole frames fit in a short run. Both BRAMs hold random data.
//            Honours VGA_TEST_PATTERN_EN for the expected colours.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_bram_display;

  typedef struct packed {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
    int fbw; int fbh;
  } geom_t;

  localparam int S_HA = 64, S_HFP = 4, S_HS = 8, S_HBP = 4;
  localparam int S_VA = 16, S_VFP = 2, S_VS = 2, S_VBP = 2;
  localparam int S_FBW = 16, S_FBH = 8;

  localparam geom_t G_BIG   = '{640, 16, 96, 48, 480, 10, 2, 33, 160, 240};
  localparam geom_t G_SMALL = '{S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, S_FBW, S_FBH};

  localparam int BIG_WORDS   = 160 * 240 / 2;
  localparam int SMALL_WORDS = S_FBW * S_FBH / 2;

  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;

  vga_bram_display_if big_if ();
  vga_bram_display_if small_if ();

  vga_bram_display u_big (
    .clk   (clk),
    .reset (reset),
    .bus   (big_if)
  );

  vga_bram_display #(
    .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
    .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
    .FB_W     (S_FBW), .FB_H (S_FBH)
  ) u_small (
    .clk   (clk),
    .reset (reset),
    .bus   (small_if)
  );

  logic [31:0] big_mem   [BIG_WORDS];
  logic [31:0] small_mem [SMALL_WORDS];
  logic [31:0] exp_addr  [2];
  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mem_word(input int sel, input int idx);
    if (sel == 0) return big_mem[idx];
    return small_mem[idx];
  endfunction

  function automatic logic [31:0] bram_rd(input int sel, input logic [31:0] addr);
    int idx;
    idx = int'(addr >> 2);
    if (sel == 0) return (idx < BIG_WORDS) ? big_mem[idx] : 32'hDEADBEEF;
    return (idx < SMALL_WORDS) ? small_mem[idx] : 32'hDEADBEEF;
  endfunction

  // Port-B BRAM models: 1-cycle read, output cleared by reset.
  always @(posedge clk) begin
    if (reset) big_if.bram_din <= 32'd0;
    else if (big_if.bram_en) big_if.bram_din <= bram_rd(0, big_if.bram_addr);
  end

  always @(posedge clk) begin
    if (reset) small_if.bram_din <= 32'd0;
    else if (small_if.bram_en) small_if.bram_din <= bram_rd(1, small_if.bram_addr);
  end

  // Framebuffer pixel shown at a raster position, -1 when blanked.
  function automatic int fb_pix(input geom_t g, input int h, input int v);
    if (h >= g.ha || v >= g.va) return -1;
    return (v / (g.va / g.fbh)) * g.fbw + h / (g.ha / g.fbw);
  endfunction

  task automatic chk(input string nm, input string fld, input int t,
                     input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s.%s t=%0d got=%h exp=%h", nm, fld, t, got, exp);
    end
  endtask

  // t = 0: in reset. t >= 1: t-th clock edge after reset release; the
  // counters sit on raster position t-1, so the fetch for that position is
  // visible at t and its sync/colour at t+2.
  task automatic check_cycle(input int sel, input int t);
    geom_t g;
    string nm;
    int ht, vt, q, h, v, p;
    logic ehs, evs, een, ghs, gvs, gen;
    logic [15:0] ergb, grgb;
    logic [31:0] w, gaddr;
    g   = (sel == 0) ? G_BIG : G_SMALL;
    nm  = (sel == 0) ? "big" : "small";
    ht  = g.ha + g.hfp + g.hs + g.hbp;
    vt  = g.va + g.vfp + g.vs + g.vbp;
    ehs = 1'b1; evs = 1'b1; ergb = 16'h0000; een = 1'b0;
    if (t == 0) exp_addr[sel] = 32'd0;
    if (t >= 3) begin
      q = (t - 3) % (ht * vt);
      h = q % ht;
      v = q / ht;
      ehs = !(h >= g.ha + g.hfp && h < g.ha + g.hfp + g.hs);
      evs = !(v >= g.va + g.vfp && v < g.va + g.vfp + g.vs);
      p = fb_pix(g, h, v);
      if (p >= 0) begin
`ifdef VGA_TEST_PATTERN_EN
        ergb = BARS[h / (g.ha / 8)];
`else
        w = mem_word(sel, p / 2);
        ergb = (p % 2 == 1) ? w[31:16] : w[15:0];
`endif
      end
    end
`ifndef VGA_TEST_PATTERN_EN
    if (t >= 1) begin
      q = (t - 1) % (ht * vt);
      h = q % ht;
      v = q / ht;
      p = fb_pix(g, h, v);
      // A word is read on the first clock of each even framebuffer pixel.
      een = (p >= 0) && (p % 2 == 0) && (h % (g.ha / g.fbw) == 0);
      if (een) exp_addr[sel] = 32'(p / 2 * 4);
    end
`endif
    if (sel == 0) begin
      ghs = big_if.vga_hsync; gvs = big_if.vga_vsync; grgb = big_if.vga_rgb;
      gen = big_if.bram_en;   gaddr = big_if.bram_addr;
    end else begin
      ghs = small_if.vga_hsync; gvs = small_if.vga_vsync; grgb = small_if.vga_rgb;
      gen = small_if.bram_en;   gaddr = small_if.bram_addr;
    end
    chk(nm, "hsync", t, 32'(ghs), 32'(ehs));
    chk(nm, "vsync", t, 32'(gvs), 32'(evs));
    chk(nm, "rgb",   t, 32'(grgb), 32'(ergb));
    chk(nm, "en",    t, 32'(gen), 32'(een));
    chk(nm, "addr",  t, gaddr, exp_addr[sel]);
  endtask

  initial begin
    int n1;
    for (int i = 0; i < BIG_WORDS; i++) big_mem[i] = $urandom();
    for (int i = 0; i < SMALL_WORDS; i++) small_mem[i] = $urandom();
    exp_addr[0] = 32'd0;
    exp_addr[1] = 32'd0;

    // Two reset clocks: idle outputs throughout.
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_cycle(0, 0);
      check_cycle(1, 0);
    end

    // Free run: several small frames, first lines of the big frame.
    reset = 1'b0;
    n1 = 3600 + int'($urandom_range(0, 900));
    for (int t = 1; t <= n1; t++) begin
      @(negedge clk);
      check_cycle(0, t);
      check_cycle(1, t);
    end

    // One-clock reset in the middle of a frame, then restart from (0,0).
    reset = 1'b1;
    @(negedge clk);
    check_cycle(0, 0);
    check_cycle(1, 0);
    reset = 1'b0;
    for (int t = 1; t <= 3600; t++) begin
      @(negedge clk);
      check_cycle(0, t);
      check_cycle(1, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
